// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - next-PC operation codes, NOP encoding and redirect decode
//
// Purpose: constants shared by the fetch sequencer, the next-PC unit and the
//          IF/ID register.
// Contents: NPC_* operation codes, INSTR_NOP, redirect_op() priority decode.
package fetch_seq_pkg;

  localparam logic [2:0]  NPC_PLUS4  = 3'b000;
  localparam logic [2:0]  NPC_BRANCH = 3'b001;
  localparam logic [2:0]  NPC_JUMP   = 3'b010;
  localparam logic [2:0]  NPC_JALR   = 3'b100;

  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

  // EX redirect sources are nominally one-hot; jalr > jal > branch if not.
  function automatic logic [2:0] redirect_op(input logic jalr,
                                             input logic jal,
                                             input logic branch);
    if (jalr)        return NPC_JALR;
    else if (jal)    return NPC_JUMP;
    else if (branch) return NPC_BRANCH;
    else             return NPC_PLUS4;
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - sticky watchdog on consecutive unanswered fetch cycles
//
// Purpose: count consecutive cycles with a request outstanding and no
//          response; raise a sticky error once TIMEOUT such cycles are seen.
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   wait_i     in   a request is outstanding this cycle
//   ready_i    in   the response arrives this cycle
//   timeout_o  out  sticky timeout flag, cleared only by reset
module fetch_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic wait_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;
  logic          r_timeout;
  logic          w_waiting;

  assign w_waiting = wait_i & ~ready_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_waiting)
        r_count <= '0;
      else if (r_count != CW'(TIMEOUT))
        r_count <= r_count + CW'(1);
      // Set at the end of the TIMEOUT-th consecutive wait cycle.
      if (w_waiting && (r_count == CW'(TIMEOUT - 1)))
        r_timeout <= 1'b1;
    end
  end

  assign timeout_o = r_timeout;

endmodule

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction-fetch sequencer: PC, imem handshake, redirects, stalls
//
// Purpose: owns the fetch PC, drives the external next-PC unit controls,
//          issues instruction-memory requests, presents fetched words to IF/ID,
//          merges EX redirects with ID load-use stalls and generates flushes.
// Ports:
//   clk, rstn                            clock, asynchronous active-low reset
//   load_use_stall                       IF/ID must hold this cycle
//   ex_branch_taken, ex_jal, ex_jalr     EX-stage redirect requests
//   ex_pc                                PC of the redirecting EX instruction
//   npc_in                               result of the next-PC unit
//   npc_op, pc_write, npc_pc             next-PC unit controls / PC operand
//   pc                                   current fetch PC
//   imem_req, imem_addr                  fetch request and address
//   imem_ready, imem_rdata               fetch response
//   if_valid, if_instr, if_pc            instruction presented to IF/ID
//   flush_ifid, flush_idex               pipeline register flushes
//   imem_timeout                         sticky fetch watchdog error
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load_use_stall,
  input  logic        ex_branch_taken,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] npc_in,
  output logic [2:0]  npc_op,
  output logic        pc_write,
  output logic [31:0] npc_pc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        imem_timeout
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_drain_addr;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;
  logic        w_redirect;
  logic        w_pass;    // forward imem_rdata straight to IF/ID
  logic        w_latch;   // capture the response into the hold buffer

  assign w_redirect = ex_jalr | ex_jal | ex_branch_taken;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_BOOT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_BOOT:  w_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          if (!w_redirect && load_use_stall) w_next = ST_HOLD;
        end else if (w_redirect) begin
          // The memory cannot cancel, so the stale response must be drained.
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: if (imem_ready) w_next = ST_FETCH;
      ST_HOLD:  if (w_redirect || !load_use_stall) w_next = ST_FETCH;
      default:  w_next = ST_BOOT;
    endcase
  end

  always_comb begin
    npc_op     = redirect_op(ex_jalr, ex_jal, ex_branch_taken);
    npc_pc     = w_redirect ? ex_pc : r_pc;
    pc_write   = w_redirect;
    flush_ifid = w_redirect;
    flush_idex = w_redirect;
    imem_req   = 1'b0;
    imem_addr  = r_pc;
    if_valid   = 1'b0;
    w_pass     = 1'b0;
    w_latch    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready && !w_redirect) begin
          if (load_use_stall) begin
            w_latch = 1'b1;
          end else begin
            if_valid = 1'b1;
            w_pass   = 1'b1;
            pc_write = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = r_drain_addr;
      end
      ST_HOLD: begin
        if (!w_redirect) begin
          if_valid = 1'b1;
          if (!load_use_stall) pc_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_hold_instr <= INSTR_NOP;
      r_hold_pc    <= RESET_PC;
    end else begin
      // With pc_write low the next-PC unit hands back the current pc.
      r_pc <= npc_in;
      if (r_state == ST_FETCH && !imem_ready && w_redirect)
        r_drain_addr <= r_pc;
      if (w_latch) begin
        r_hold_instr <= imem_rdata;
        r_hold_pc    <= r_pc;
      end
    end
  end

  assign pc       = r_pc;
  assign if_instr = w_pass ? imem_rdata : r_hold_instr;
  assign if_pc    = w_pass ? r_pc       : r_hold_pc;

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rstn      (rstn),
    .wait_i    (imem_req),
    .ready_i   (imem_ready),
    .timeout_o (imem_timeout)
  );

endmodule
